// File: rtl/contador_ctrl.sv
// Run controller for the 4-digit BCD counter chain.
// Turns start/stop/clear button edges into an IDLE/RUN/PAUSE/DONE sequence.
// A prescaler divides the clock into one-cycle count-enable pulses for digit 0.
// A clear request produces a one-cycle counter clear.
// Counting halts once the counter reaches the BCD target.
module contador_ctrl #(
  parameter int unsigned DIV_CNT = 50000000,
  parameter int unsigned DIV_W   = 26
) (
  input  logic        clk_ctrl,
  input  logic        rstn_ctrl,
  input  logic        start_btn,
  input  logic        stop_btn,
  input  logic        clear_btn,
  input  logic [15:0] target_bcd,
  input  logic [15:0] qdata_in,
  output logic        ena0_out,
  output logic        rst_cnt,
  output logic [1:0]  state_out,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV_CNT - 1);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic               start_prev_q, stop_prev_q, clear_prev_q;
  logic               start_edge, stop_edge, clear_edge;
  logic               ena0_q, ena0_d;
  logic               rst_cnt_q, rst_cnt_d;
  logic               done_q, done_d;
  logic               target_hit;
  logic               presc_wrap;

  assign start_edge = start_btn & ~start_prev_q;
  assign stop_edge  = stop_btn  & ~stop_prev_q;
  assign clear_edge = clear_btn & ~clear_prev_q;

  // A target digit above 9 can never equal a BCD count, so such targets free-run.
  assign target_hit = (qdata_in == target_bcd);
  assign presc_wrap = (presc_q == PRESC_LAST);

  // Button history; preset high so a button held through reset gives no edge.
  always_ff @(posedge clk_ctrl or negedge rstn_ctrl) begin
    if (!rstn_ctrl) begin
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
      clear_prev_q <= 1'b1;
    end else begin
      start_prev_q <= start_btn;
      stop_prev_q  <= stop_btn;
      clear_prev_q <= clear_btn;
    end
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk_ctrl or negedge rstn_ctrl) begin
    if (!rstn_ctrl) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      ena0_q    <= 1'b0;
      rst_cnt_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ena0_q    <= ena0_d;
      rst_cnt_q <= rst_cnt_d;
      done_q    <= done_d;
    end
  end

  // Next state and prescaler; clear beats stop beats start.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (clear_edge) begin
      state_d = S_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          // Stop freezes the prescaler so resuming keeps the pulse spacing.
          if (stop_edge) begin
            state_d = S_PAUSE;
          end else if (target_hit) begin
            state_d = S_DONE;
          end else if (presc_wrap) begin
            presc_d = '0;
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
        S_PAUSE: begin
          if (start_edge) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  // Output next values.
  // The pulse fires only on an undisturbed RUN wrap, so it never overlaps the clear.
  always_comb begin
    ena0_d    = (state_q == S_RUN) && presc_wrap && !clear_edge && !stop_edge && !target_hit;
    rst_cnt_d = clear_edge;
    done_d    = (state_d == S_DONE);
  end

  assign ena0_out  = ena0_q;
  assign rst_cnt   = rst_cnt_q;
  assign state_out = state_q;
  assign done      = done_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// Bench for contador_ctrl: a behavioural BCD counter driven by the controller,
// a reference model of the run rules, and directed scenarios plus random buttons.
module tb_contador_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_btn, stop_btn, clear_btn;
  logic [15:0] target_bcd, qdata;
  logic        t_ena, t_rst, t_done;
  logic [1:0]  t_state;

  logic        start2;
  logic [15:0] target2, qdata2;
  logic        ena2, rst2, done2;
  logic [1:0]  state2;
  logic        pre2_en;
  int          pre2_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    int x;
    x = v % 10000;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  contador_ctrl #(.DIV_CNT(DIV), .DIV_W(26)) dut (
    .clk_ctrl(clk), .rstn_ctrl(rstn), .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .target_bcd(target_bcd), .qdata_in(qdata),
    .ena0_out(t_ena), .rst_cnt(t_rst), .state_out(t_state), .done(t_done)
  );

  contador_ctrl #(.DIV_CNT(2), .DIV_W(26)) dut2 (
    .clk_ctrl(clk), .rstn_ctrl(rstn), .start_btn(start2), .stop_btn(1'b0),
    .clear_btn(1'b0), .target_bcd(target2), .qdata_in(qdata2),
    .ena0_out(ena2), .rst_cnt(rst2), .state_out(state2), .done(done2)
  );

  // Counter chains fed by the controllers.
  int   cnt, cnt2;
  logic wrapped2;
  assign qdata  = to_bcd(cnt);
  assign qdata2 = to_bcd(cnt2);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= 0;
    else if (t_rst) cnt <= 0;
    else if (t_ena) cnt <= (cnt + 1) % 10000;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt2 <= 0;
      wrapped2 <= 1'b0;
    end else if (pre2_en) begin
      cnt2 <= pre2_val;
    end else if (rst2) begin
      cnt2 <= 0;
    end else if (ena2) begin
      if (cnt2 == 9999) wrapped2 <= 1'b1;
      cnt2 <= (cnt2 + 1) % 10000;
    end
  end

  // Reference model: run_ticks counts RUN cycles since start, surviving pauses;
  // a pulse is due whenever it reaches a multiple of DIV.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int         m_mode, m_ticks;
  logic       m_ps, m_pt, m_pc;
  logic       exp_ena, exp_rst, exp_done;
  logic [1:0] exp_state;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode <= M_IDLE; m_ticks <= 0;
      m_ps <= 1'b1; m_pt <= 1'b1; m_pc <= 1'b1;
      exp_ena <= 1'b0; exp_rst <= 1'b0; exp_done <= 1'b0; exp_state <= 2'd0;
    end else begin : mstep
      logic se, te, ce, pulse;
      int   md, tk;
      se = start_btn & ~m_ps;
      te = stop_btn & ~m_pt;
      ce = clear_btn & ~m_pc;
      md = m_mode;
      tk = m_ticks;
      pulse = 1'b0;
      if (ce) begin
        md = M_IDLE;
        tk = 0;
      end else if (m_mode == M_IDLE && se) begin
        md = M_RUN;
        tk = 0;
      end else if (m_mode == M_PAUSE && se) begin
        md = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (te) md = M_PAUSE;
        else if (qdata == target_bcd) md = M_DONE;
        else begin
          tk = tk + 1;
          pulse = (tk % DIV == 0);
        end
      end
      m_mode <= md; m_ticks <= tk;
      m_ps <= start_btn; m_pt <= stop_btn; m_pc <= clear_btn;
      exp_ena <= pulse; exp_rst <= ce; exp_done <= (md == M_DONE); exp_state <= 2'(md);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ena0", 32'(t_ena), 32'(exp_ena));
    chk("rst_cnt", 32'(t_rst), 32'(exp_rst));
    chk("state", 32'(t_state), 32'(exp_state));
    chk("done", 32'(t_done), 32'(exp_done));
    chk("ena_rst_excl", 32'(t_ena & t_rst), 32'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, pulses, bad;
    logic [15:0] qhold;
    rstn = 1'b0;
    start_btn = 1'b0; stop_btn = 1'b0; clear_btn = 1'b0;
    target_bcd = 16'hFFFF;
    start2 = 1'b0; target2 = 16'h00A0; pre2_en = 1'b0; pre2_val = 0;
    repeat (3) tick;
    chk("rst_state", 32'(t_state), 32'd0);
    chk("rst_ena", 32'(t_ena), 32'd0);
    chk("rst_done", 32'(t_done), 32'd0);
    rstn = 1'b1;
    tick;

    // Start edge: RUN next cycle, pulses at N+5, N+9, N+13.
    start_btn = 1'b1;
    tick;
    chk("t2_state_run", 32'(t_state), 32'd1);
    start_btn = 1'b0;
    for (int k = 2; k <= 14; k++) begin
      tick;
      chk("t2_ena_timing", 32'(t_ena), 32'((k == 5) || (k == 9) || (k == 13)));
    end

    // Stop two cycles after a pulse, hold, resume.
    w = 0;
    while (!t_ena && w < 10) begin tick; w++; end
    chk("t3_pulse_found", 32'(t_ena), 32'd1);
    tick; tick;
    stop_btn = 1'b1;
    tick;
    chk("t3_state_pause", 32'(t_state), 32'd2);
    stop_btn = 1'b0;
    qhold = qdata;
    pulses = 0;
    repeat (20) begin tick; if (t_ena) pulses++; end
    chk("t3_no_pulse_paused", 32'(pulses), 32'd0);
    chk("t3_qdata_hold", 32'(qdata), 32'(qhold));
    start_btn = 1'b1;
    tick;
    chk("t3_state_resume", 32'(t_state), 32'd1);
    start_btn = 1'b0;
    tick;
    chk("t3_resume_ena_r1", 32'(t_ena), 32'd0);
    tick;
    chk("t3_resume_ena_r2", 32'(t_ena), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("t3_spacing", 32'(t_ena), 32'(k == 4));
    end

    // Asynchronous reset mid-RUN, released with start held.
    #2;
    start_btn = 1'b1;
    rstn = 1'b0;
    #1;
    chk("t1_async_state", 32'(t_state), 32'd0);
    chk("t1_async_ena", 32'(t_ena), 32'd0);
    chk("t1_async_rst", 32'(t_rst), 32'd0);
    chk("t1_async_done", 32'(t_done), 32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    pulses = 0;
    repeat (10) begin tick; if (t_ena) pulses++; end
    chk("t1_held_idle", 32'(t_state), 32'd0);
    chk("t1_held_no_pulse", 32'(pulses), 32'd0);
    start_btn = 1'b0;
    tick;

    // Run to target 0012.
    target_bcd = 16'h0012;
    clear_btn = 1'b1;
    tick;
    chk("t4_clear_pulse", 32'(t_rst), 32'd1);
    clear_btn = 1'b0;
    tick;
    chk("t4_cleared", 32'(qdata), 32'h0);
    start_btn = 1'b1;
    tick;
    start_btn = 1'b0;
    pulses = 0; w = 0;
    while (!t_done && w < 100) begin tick; if (t_ena) pulses++; w++; end
    chk("t4_done", 32'(t_done), 32'd1);
    chk("t4_state_done", 32'(t_state), 32'd3);
    chk("t4_qdata", 32'(qdata), 32'h0012);
    chk("t4_pulse_count", 32'(pulses), 32'd12);
    stop_btn = 1'b1;
    tick;
    start_btn = 1'b1; stop_btn = 1'b0;
    tick;
    start_btn = 1'b0;
    repeat (6) begin tick; if (t_ena) pulses++; end
    chk("t4_done_sticky", 32'(t_state), 32'd3);
    chk("t4_no_extra_pulse", 32'(pulses), 32'd12);
    chk("t4_qdata_final", 32'(qdata), 32'h0012);

    // Clear and start together in RUN, on the cycle a pulse would fire.
    clear_btn = 1'b1;
    tick;
    clear_btn = 1'b0;
    tick;
    target_bcd = 16'hFFFF;
    start_btn = 1'b1;
    tick;
    start_btn = 1'b0;
    repeat (7) tick;
    clear_btn = 1'b1; start_btn = 1'b1;
    tick;
    chk("t5_rst_cnt", 32'(t_rst), 32'd1);
    chk("t5_state_idle", 32'(t_state), 32'd0);
    chk("t5_no_pulse", 32'(t_ena), 32'd0);
    clear_btn = 1'b0; start_btn = 1'b0;
    tick;
    chk("t5_qdata_zero", 32'(qdata), 32'h0);
    chk("t5_rst_one_cycle", 32'(t_rst), 32'd0);

    // Invalid target with DIV_CNT=2: counter wraps 9999 -> 0000 and keeps running.
    pre2_val = 9990; pre2_en = 1'b1;
    tick;
    pre2_en = 1'b0;
    chk("t6_preload", 32'(qdata2), 32'h9990);
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    chk("t6_state_run", 32'(state2), 32'd1);
    pulses = 0; bad = 0;
    for (int k = 2; k <= 40; k++) begin
      tick;
      if (ena2) pulses++;
      if (state2 != 2'd1 || done2) bad++;
    end
    chk("t6_pulses", 32'(pulses), 32'd19);
    chk("t6_wrapped", 32'(wrapped2), 32'd1);
    chk("t6_stay_run", 32'(bad), 32'd0);
    chk("t6_qdata", 32'(qdata2), 32'h0009);

    // Random buttons and targets, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 9) == 0) stop_btn = ~stop_btn;
      if ($urandom_range(0, 59) == 0) clear_btn = ~clear_btn;
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 3) == 0) target_bcd = 16'hA000 | to_bcd(int'($urandom_range(0, 99)));
        else target_bcd = to_bcd(cnt + int'($urandom_range(1, 6)));
      end
      tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
